// File: rtl/id_imm_ctrl.sv
// ID-stage controller: opcode decode, ImmSrc select, load-use bubble insertion and ID/EX control register.
// Optional feature: define ID_STALL_CNT_EN to add the saturating stall_cnt output.
module id_imm_ctrl #(
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  output logic             id_ready,
  output logic [1:0]       imm_src,
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_alu_src,
  output logic             ex_branch,
  output logic             ex_jump,
  output logic [1:0]       ex_result_src,
  output logic [4:0]       ex_rd,
  output logic             ex_illegal
`ifdef ID_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [1:0] LU_CNT = 2'(LU_BUBBLES - 1);

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_t;

  state_t     state, state_next;
  logic [1:0] cnt, cnt_next;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2, rd;

  logic       dec_reg_write, dec_mem_read, dec_mem_write, dec_alu_src;
  logic       dec_branch, dec_jump, dec_illegal;
  logic [1:0] dec_result_src;
  logic       uses_rs1, uses_rs2;

  logic       hazard, advance;
  logic       load_bubble, load_decode;

  assign opcode = id_instr[6:0];
  assign rd     = id_instr[11:7];
  assign rs1    = id_instr[19:15];
  assign rs2    = id_instr[24:20];

  logic unused_instr_bits;
  assign unused_instr_bits = ^{id_instr[31:25], id_instr[14:12]};

  // Unknown opcodes (LUI/AUIPC included) still read rs1 for hazard purposes.
  always_comb begin
    imm_src        = 2'b00;
    dec_reg_write  = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_alu_src    = 1'b0;
    dec_branch     = 1'b0;
    dec_jump       = 1'b0;
    dec_result_src = 2'b00;
    dec_illegal    = 1'b0;
    uses_rs1       = 1'b1;
    uses_rs2       = 1'b0;
    case (opcode)
      OP_LOAD: begin
        dec_reg_write  = 1'b1;
        dec_mem_read   = 1'b1;
        dec_alu_src    = 1'b1;
        dec_result_src = 2'b01;
      end
      OP_IMM: begin
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
      end
      OP_JALR: begin
        dec_reg_write  = 1'b1;
        dec_alu_src    = 1'b1;
        dec_jump       = 1'b1;
        dec_result_src = 2'b10;
      end
      OP_STORE: begin
        imm_src       = 2'b01;
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
        uses_rs2      = 1'b1;
      end
      OP_BRANCH: begin
        imm_src    = 2'b10;
        dec_branch = 1'b1;
        uses_rs2   = 1'b1;
      end
      OP_JAL: begin
        imm_src        = 2'b11;
        dec_reg_write  = 1'b1;
        dec_jump       = 1'b1;
        dec_result_src = 2'b10;
        uses_rs1       = 1'b0;
      end
      OP_OP: begin
        dec_reg_write = 1'b1;
        uses_rs2      = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign hazard = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid &&
                  ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
  assign advance  = !ex_valid || ex_ready;
  assign id_ready = advance && !hazard && (state == RUN) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Flush wins over everything; BUBBLE keeps writing empty entries until the count runs out.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    load_bubble = 1'b0;
    load_decode = 1'b0;
    if (flush) begin
      state_next = RUN;
      cnt_next   = 2'd0;
    end else begin
      case (state)
        RUN: begin
          if (hazard && advance) begin
            load_bubble = 1'b1;
            cnt_next    = LU_CNT;
            state_next  = (LU_CNT != 2'd0) ? BUBBLE : RUN;
          end else if (advance) begin
            load_decode = 1'b1;
          end
        end
        BUBBLE: begin
          load_bubble = 1'b1;
          if (cnt <= 2'd1) begin
            cnt_next   = 2'd0;
            state_next = RUN;
          end else begin
            cnt_next = cnt - 2'd1;
          end
        end
        default: begin
          state_next = RUN;
          cnt_next   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_branch     <= 1'b0;
      ex_jump       <= 1'b0;
      ex_result_src <= 2'b00;
      ex_rd         <= 5'd0;
      ex_illegal    <= 1'b0;
    end else if (flush || load_bubble) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_branch     <= 1'b0;
      ex_jump       <= 1'b0;
      ex_result_src <= 2'b00;
      ex_rd         <= 5'd0;
      ex_illegal    <= 1'b0;
    end else if (load_decode) begin
      ex_valid      <= id_valid;
      ex_reg_write  <= dec_reg_write;
      ex_mem_read   <= dec_mem_read;
      ex_mem_write  <= dec_mem_write;
      ex_alu_src    <= dec_alu_src;
      ex_branch     <= dec_branch;
      ex_jump       <= dec_jump;
      ex_result_src <= dec_result_src;
      ex_rd         <= rd;
      ex_illegal    <= dec_illegal;
    end
  end

`ifdef ID_STALL_CNT_EN
  // Counts every cycle a valid ID instruction is held back, whatever the cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (id_valid && !id_ready && !flush && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_id_imm_ctrl.sv
// Testbench for id_imm_ctrl: two instances (LU_BUBBLES 1 and 3), scoreboard-checked against a decode/hazard model.
// Define ID_STALL_CNT_EN to also check the stall counter.
module tb_id_imm_ctrl;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [1:0] result_src;
    logic [4:0] rd;
    logic       illegal;
  } entry_t;

  localparam logic [31:0] ADDI_X1   = 32'h00500093;
  localparam logic [31:0] SW_I      = 32'h0020A223;
  localparam logic [31:0] BEQ_I     = 32'h00208463;
  localparam logic [31:0] JAL_I     = 32'h008000EF;
  localparam logic [31:0] LUI_I     = 32'h000012B7;
  localparam logic [31:0] AUIPC_I   = 32'h00000517;
  localparam logic [31:0] ADD_X3    = 32'h002081B3;
  localparam logic [31:0] LW_X5     = 32'h0000A283;
  localparam logic [31:0] LW_X0     = 32'h0000A003;
  localparam logic [31:0] LW_X5_X5  = 32'h0002A283;
  localparam logic [31:0] ADD_DEP   = 32'h00228333;
  localparam logic [31:0] ADD_X0    = 32'h00200333;
  localparam logic [31:0] ADDI_DEP  = 32'h00128313;
  localparam logic [31:0] ADDI_NODP = 32'h00508313;
  localparam logic [31:0] ADD_RS2   = 32'h00510333;
  localparam logic [31:0] JAL_FIELD = 32'h000280EF;

  logic clk;
  int   checks = 0;
  int   errors = 0;
  bit   done [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check_output(input int lu, input string name,
                                       input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL lu%0d %s: got %0h expected %0h", lu, name, got, exp);
    end
  endfunction

  // Reference decode, straight from the opcode table.
  function automatic entry_t ref_entry(input logic [31:0] instr);
    entry_t e;
    e    = '0;
    e.rd = instr[11:7];
    case (instr[6:0])
      7'b0000011: begin e.reg_write = 1; e.mem_read = 1; e.alu_src = 1; e.result_src = 2'b01; end
      7'b0010011: begin e.reg_write = 1; e.alu_src = 1; end
      7'b1100111: begin e.reg_write = 1; e.alu_src = 1; e.jump = 1; e.result_src = 2'b10; end
      7'b0100011: begin e.mem_write = 1; e.alu_src = 1; end
      7'b1100011: e.branch = 1;
      7'b1101111: begin e.reg_write = 1; e.jump = 1; e.result_src = 2'b10; end
      7'b0110011: e.reg_write = 1;
      default:    e.illegal = 1;
    endcase
    return e;
  endfunction

  function automatic logic [1:0] ref_imm(input logic [31:0] instr);
    case (instr[6:0])
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  // Stall cycles for an instruction issued right behind a load writing load_rd (0 = no load).
  function automatic int ref_stall(input logic [4:0] load_rd, input logic [31:0] instr, input int lu);
    logic [6:0] op;
    bit r1, r2;
    op = instr[6:0];
    r1 = (op != 7'b1101111);
    r2 = (op inside {7'b0100011, 7'b1100011, 7'b0110011});
    if (load_rd == 5'd0) return 0;
    if ((r1 && instr[19:15] == load_rd) || (r2 && instr[24:20] == load_rd)) return lu;
    return 0;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] op, hi;
    logic [2:0] f3;
    logic [4:0] rd, r1, r2;
    case ($urandom_range(0, 9))
      0, 1:    op = 7'b0000011;
      2:       op = 7'b0010011;
      3:       op = 7'b1100111;
      4:       op = 7'b0100011;
      5:       op = 7'b1100011;
      6:       op = 7'b1101111;
      7:       op = 7'b0110011;
      8:       op = 7'b0110111;
      default: op = 7'($urandom);
    endcase
    hi = 7'($urandom);
    f3 = 3'($urandom);
    rd = 5'($urandom_range(0, 3));
    r1 = 5'($urandom_range(0, 3));
    r2 = 5'($urandom_range(0, 3));
    return {hi, r2, r1, f3, rd, op};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : h
    localparam int LU = (g == 0) ? 1 : 3;

    logic        rst_n, flush, id_valid, id_ready, ex_ready, ex_valid;
    logic [31:0] id_instr;
    logic [1:0]  imm_src, ex_result_src;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch, ex_jump, ex_illegal;
    logic [4:0]  ex_rd;
`ifdef ID_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif
    entry_t      obs;
    entry_t      sb [$];
    logic [4:0]  prev_load_rd;
    bit          hold_prev;

    assign obs = {ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch,
                  ex_jump, ex_result_src, ex_rd, ex_illegal};

    id_imm_ctrl #(.LU_BUBBLES(LU), .CNT_W(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .id_valid      (id_valid),
      .id_instr      (id_instr),
      .id_ready      (id_ready),
      .imm_src       (imm_src),
      .ex_ready      (ex_ready),
      .ex_valid      (ex_valid),
      .ex_reg_write  (ex_reg_write),
      .ex_mem_read   (ex_mem_read),
      .ex_mem_write  (ex_mem_write),
      .ex_alu_src    (ex_alu_src),
      .ex_branch     (ex_branch),
      .ex_jump       (ex_jump),
      .ex_result_src (ex_result_src),
      .ex_rd         (ex_rd),
      .ex_illegal    (ex_illegal)
`ifdef ID_STALL_CNT_EN
      ,
      .stall_cnt     (stall_cnt)
`endif
    );

    // Present one instruction until accepted; in fixed-ready mode the stall length is checked.
    task automatic apply_stimulus(input logic [31:0] instr, input bit rnd);
      int waited;
      int exp_st;
      waited = 0;
      exp_st = ref_stall(prev_load_rd, instr, LU);
      forever begin
        @(negedge clk);
        id_valid = 1'b1;
        id_instr = instr;
        ex_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        #1;
        if (waited == 0) check_output(LU, "imm_src", 32'(imm_src), 32'(ref_imm(instr)));
        if (id_ready) break;
        waited++;
        if (waited > 40) begin
          checks++;
          errors++;
          $display("[TB] FAIL lu%0d accept_timeout: waited %0d cycles, limit 40", LU, waited);
          return;
        end
      end
      sb.push_back(ref_entry(instr));
      if (!rnd) check_output(LU, "stall_cycles", waited, exp_st);
      prev_load_rd = (instr[6:0] == 7'b0000011) ? instr[11:7] : 5'd0;
    endtask

    task automatic idle(input int n, input bit rnd);
      repeat (n) begin
        @(negedge clk);
        id_valid = 1'b0;
        ex_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      prev_load_rd = 5'd0;
    endtask

    initial begin
      rst_n = 1'b0; flush = 1'b0; id_valid = 1'b0; id_instr = '0; ex_ready = 1'b0;
      prev_load_rd = 5'd0;
      repeat (2) @(negedge clk);
      #1;
      check_output(LU, "reset_ex", 32'({ex_valid, obs}), 32'd0);
`ifdef ID_STALL_CNT_EN
      check_output(LU, "reset_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1; ex_ready = 1'b1;
      #1;
      check_output(LU, "reset_id_ready", 32'(id_ready), 32'd1);

      apply_stimulus(ADDI_X1, 1'b0);
      @(negedge clk);
      id_valid = 1'b0;
      #1;
      check_output(LU, "latency_valid", 32'(ex_valid), 32'd1);
      check_output(LU, "latency_entry", {18'd0, obs}, {18'd0, ref_entry(ADDI_X1)});
      prev_load_rd = 5'd0;

      apply_stimulus(SW_I, 1'b0);
      apply_stimulus(BEQ_I, 1'b0);
      apply_stimulus(JAL_I, 1'b0);
      apply_stimulus(LUI_I, 1'b0);
      apply_stimulus(AUIPC_I, 1'b0);
      apply_stimulus(ADD_X3, 1'b0);

      apply_stimulus(LW_X5, 1'b0);    apply_stimulus(ADD_DEP, 1'b0);
      apply_stimulus(LW_X0, 1'b0);    apply_stimulus(ADD_X0, 1'b0);
      apply_stimulus(LW_X5, 1'b0);    apply_stimulus(ADDI_DEP, 1'b0);
      apply_stimulus(LW_X5, 1'b0);    apply_stimulus(ADDI_NODP, 1'b0);
      apply_stimulus(LW_X5, 1'b0);    apply_stimulus(ADD_RS2, 1'b0);
      apply_stimulus(LW_X5, 1'b0);    apply_stimulus(JAL_FIELD, 1'b0);
      apply_stimulus(LW_X5, 1'b0);    apply_stimulus(LW_X5_X5, 1'b0);
      apply_stimulus(ADD_DEP, 1'b0);
      apply_stimulus(LW_X5, 1'b0);    idle(1, 1'b0);   apply_stimulus(ADD_DEP, 1'b0);

      // Flush while the bubble sequence is running: the dependent add is killed.
      apply_stimulus(LW_X5, 1'b0);
      @(negedge clk);
      id_valid = 1'b1; id_instr = ADD_DEP; ex_ready = 1'b1;
      #1;
      check_output(LU, "flush_pre_hazard", 32'(id_ready), 32'd0);
      @(negedge clk);
      flush = 1'b1;
      #1;
      check_output(LU, "flush_id_ready", 32'(id_ready), 32'd0);
      @(negedge clk);
      flush = 1'b0; id_valid = 1'b0;
      #1;
      check_output(LU, "flush_ex_valid", 32'(ex_valid), 32'd0);
      check_output(LU, "flush_run_ready", 32'(id_ready), 32'd1);
      prev_load_rd = 5'd0;

      // Reset in the middle of the bubble sequence.
      apply_stimulus(LW_X5, 1'b0);
      @(negedge clk);
      id_valid = 1'b1; id_instr = ADD_DEP; ex_ready = 1'b1;
      @(negedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_output(LU, "rst_mid_ex", 32'({ex_valid, obs}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; id_valid = 1'b0;
      #1;
      check_output(LU, "rst_mid_ready", 32'(id_ready), 32'd1);
`ifdef ID_STALL_CNT_EN
      check_output(LU, "rst_mid_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
      prev_load_rd = 5'd0;
      apply_stimulus(ADD_DEP, 1'b0);

      // Four cycles of EX backpressure with a valid entry.
      @(negedge clk);
      ex_ready = 1'b0; id_valid = 1'b1; id_instr = ADD_X3;
      #1;
      for (int i = 0; i < 4; i++) begin
        if (i > 0) begin
          @(negedge clk);
          #1;
        end
        check_output(LU, "bp_id_ready", 32'(id_ready), 32'd0);
        check_output(LU, "bp_ex_valid", 32'(ex_valid), 32'd1);
      end
      @(negedge clk);
      id_valid = 1'b0; ex_ready = 1'b1;
      #1;
      check_output(LU, "bp_hold", {18'd0, obs}, {18'd0, ref_entry(ADD_DEP)});
`ifdef ID_STALL_CNT_EN
      check_output(LU, "bp_stall_cnt", 32'(stall_cnt), 32'd4);
`endif
      prev_load_rd = 5'd0;

      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(0, 3) == 0) idle(1, 1'b0);
        apply_stimulus(rand_instr(), 1'b0);
      end
      for (int i = 0; i < 80; i++) begin
        if ($urandom_range(0, 3) == 0) idle(1, 1'b1);
        apply_stimulus(rand_instr(), 1'b1);
      end
      idle(6, 1'b0);
      #3;
      check_output(LU, "drain_empty", sb.size(), 0);
      done[g] = 1'b1;
    end

    // Monitor: every valid ID/EX entry must match the scoreboard head; pop when EX takes it.
    initial hold_prev = 1'b0;
    always begin
      @(negedge clk);
      #2;
      if (hold_prev) check_output(LU, "hold_valid", 32'(ex_valid), 32'd1);
      if (rst_n && ex_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL lu%0d unexpected_entry: got %0h expected none", LU, obs);
        end else begin
          check_output(LU, "ex_entry", {18'd0, obs}, {18'd0, sb[0]});
          if (ex_ready) void'(sb.pop_front());
        end
      end
      hold_prev = rst_n && !flush && ex_valid && !ex_ready;
    end
  end

  initial begin
    wait (done[0] && done[1]);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    checks++;
    errors++;
    $display("[TB] FAIL global_timeout: got unfinished expected done");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_imm_ctrl.md
Name: id_imm_ctrl

Overview:
- ID-stage controller that sequences the immediate extender and the ID/EX control register of the 5-stage RV32 pipeline.
- Decodes the opcode of the instruction in ID into the 2-bit ImmSrc select and the main control bundle.
- Detects load-use hazards and inserts bubbles.
- Registers the decoded controls into ID/EX under a valid/ready handshake with IF and EX.

Parameters:
- LU_BUBBLES, 1: bubbles inserted per load-use hazard (1..3).
- CNT_W, 16: width of the stall counter (optional feature only).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  branch/jump redirect from EX; kills the ID instruction
- id_valid  in  1  IF/ID holds a valid instruction
- id_instr  in  32  instruction in ID
- id_ready  out  1  ID accepts id_instr this cycle
- imm_src  out  2  combinational select to extender: 00 I, 01 S, 10 B, 11 J
- ex_ready  in  1  EX can accept an ID/EX entry
- ex_valid  out  1  ID/EX entry valid
- ex_reg_write  out  1  registered control
- ex_mem_read  out  1  registered control
- ex_mem_write  out  1  registered control
- ex_alu_src  out  1  registered control, 1 = immediate operand
- ex_branch  out  1  registered control
- ex_jump  out  1  registered control, JAL or JALR
- ex_result_src  out  2  registered control: 00 ALU, 01 mem, 10 PC+4
- ex_rd  out  5  registered destination register
- ex_illegal  out  1  registered unsupported-opcode flag

Behaviour:
- Reset is asynchronous. All ex_* outputs are 0, state is RUN, and the bubble counter is 0.
- Decode is combinational on id_instr[6:0]:
  - 0000011 LOAD: imm 00, reg_write, mem_read, alu_src, result 01.
  - 0010011 OP-IMM: imm 00, reg_write, alu_src, result 00.
  - 1100111 JALR: imm 00, reg_write, alu_src, jump, result 10.
  - 0100011 STORE: imm 01, mem_write, alu_src.
  - 1100011 BRANCH: imm 10, branch.
  - 1101111 JAL: imm 11, reg_write, jump, result 10.
  - 0110011 OP: imm 00, reg_write, result 00.
  - Any other opcode, including LUI and AUIPC: imm 00, all controls 0, illegal = 1.
- imm_src follows id_instr every cycle, regardless of state.
- rs1 use: all opcodes except JAL. rs2 use: STORE, BRANCH and OP only. A source register x0 never causes a hazard.
- Hazard condition: ex_valid & ex_mem_read & (ex_rd != 0) & (ex_rd matches a used rs1 or rs2 of id_instr) & id_valid.
- advance = ~ex_valid | ex_ready.
- FSM state RUN:
  - Hazard & advance: load a bubble into ID/EX (ex_valid=0, controls 0), set cnt = LU_BUBBLES-1, go to BUBBLE if cnt != 0, else stay in RUN.
  - Otherwise, if advance: ID/EX takes the decoded id_instr with ex_valid = id_valid.
  - Otherwise: hold ID/EX.
- FSM state BUBBLE:
  - Each cycle: ex_valid = 0, decrement cnt.
  - At cnt == 0, return to RUN.
- id_ready = advance & ~hazard & (state == RUN).
- Registered outputs give 1-cycle latency from acceptance to ex_valid.
- flush has top priority:
  - Next edge: ex_valid = 0, all ex_* controls = 0, state = RUN, cnt = 0.
  - id_ready = 0 in the flush cycle.
- While ex_valid & ~ex_ready, all ex_* outputs stay stable.
- An entry holding ex_mem_read=1 that is stalled keeps the hazard asserted until it drains.
- Reset asserted mid-bubble returns to RUN immediately with all outputs 0.

Optional Feature:
- Macro: ID_STALL_CNT_EN.
- When defined:
  - Extra port stall_cnt out CNT_W: counts cycles where id_valid & ~id_ready & ~flush.
  - Saturates at all-ones.
  - Cleared by rst_n.
  - Counts both hazard and backpressure stalls.
- When undefined: the port and counter are absent. Behaviour is otherwise identical.

Test Plan:
- Reset release, id_valid=1, id_instr=0x00500093 (addi x1,x0,5), ex_ready=1 -> imm_src=00 same cycle; next cycle ex_valid=1, reg_write=1, alu_src=1, ex_rd=1, result_src=00.
- Decode sweep of sw (0x0020A223), beq (0x00208463), jal (0x008000EF):
  - imm_src = 01, 10, 11 respectively.
  - jal: ex_jump=1, result_src=10.
  - sw: mem_write=1, reg_write=0.
- Load-use: lw x5,0(x1), then add x6,x5,x2 with LU_BUBBLES=1:
  - add sees id_ready=0 for 1 cycle while a bubble (ex_valid=0) is written.
  - add is accepted the next cycle.
  - Repeat with LU_BUBBLES=3 -> 3 bubbles.
- lw x0,0(x1) followed by add x6,x0,x2 -> no stall. add following lw x5 with rs2 unused (addi x6,x5,1) -> stall.
- ex_ready=0 for 4 cycles with ex_valid=1:
  - ex_* outputs constant, id_ready=0.
  - With ID_STALL_CNT_EN, stall_cnt increments by 4.
- flush asserted during BUBBLE -> next cycle state RUN, ex_valid=0, id_ready follows advance. LUI opcode 0110111 -> ex_illegal=1, all controls 0.
